// File: rtl/byte_striping_pkg.sv
// Shared definitions for the byte striping transmit/receive pair:
// state encoding, default widths and small counter helpers.
package byte_striping_pkg;

    // Pairing state: IDLE has no pending word, HALF holds the even word.
    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } state_e;

    localparam int WIDTH_DEF     = 32;
    localparam int FLUSH_CYC_DEF = 4;

    // Flush counter width; the counter saturates at its maximum.
    localparam int FLUSH_CNT_W = 4;

    // Counter value at which the next idle cycle triggers a flush.
    // Out-of-range settings are clamped into the legal 1..15 window.
    function automatic logic [3:0] flush_limit(input int cyc);
        logic [3:0] lim;
        if (cyc <= 1) begin
            lim = 4'd0;
        end else if (cyc >= 15) begin
            lim = 4'd14;
        end else begin
            lim = 4'(cyc - 1);
        end
        return lim;
    endfunction

    // Saturating increment for the 4-bit flush counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] val);
        logic [3:0] res;
        if (val == 4'hF) begin
            res = val;
        end else begin
            res = val + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/byte_striping_tx_lane_hold_timer.sv
// Presentation timer for the striped lanes: every load raises the lane
// valids for exactly two clk_2f cycles, and a load landing on the second
// cycle of a previous window restarts the window with no valid gap.
module lane_hold_timer (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_pair_i,
    input  logic load_single_i,
    output logic valid_0_o,
    output logic valid_1_o
);

    // Cycles left in the current window after the present one.
    logic [1:0] pres_q;
    logic [1:0] pres_d;
    logic       valid_0_q;
    logic       valid_0_d;
    logic       valid_1_q;
    logic       valid_1_d;

    // Next-state: a load opens a fresh window, otherwise count it down.
    always_comb begin
        pres_d    = pres_q;
        valid_0_d = valid_0_q;
        valid_1_d = valid_1_q;
        if (load_pair_i) begin
            pres_d    = 2'd1;
            valid_0_d = 1'b1;
            valid_1_d = 1'b1;
        end else if (load_single_i) begin
            pres_d    = 2'd1;
            valid_0_d = 1'b1;
            valid_1_d = 1'b0;
        end else if (pres_q != 2'd0) begin
            pres_d    = pres_q - 2'd1;
            valid_0_d = valid_0_q;
            valid_1_d = valid_1_q;
        end else begin
            pres_d    = 2'd0;
            valid_0_d = 1'b0;
            valid_1_d = 1'b0;
        end
    end

    // Window registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pres_q    <= 2'd0;
            valid_0_q <= 1'b0;
            valid_1_q <= 1'b0;
        end else begin
            pres_q    <= pres_d;
            valid_0_q <= valid_0_d;
            valid_1_q <= valid_1_d;
        end
    end

    assign valid_0_o = valid_0_q;
    assign valid_1_o = valid_1_q;

endmodule

// File: rtl/byte_striping_tx.sv
// Byte striping transmitter: pairs consecutive input words onto two
// half-rate lanes (even word on lane0, odd word on lane1). A lone even
// word is flushed onto lane0 after FLUSH_CYC idle cycles.
module byte_striping_tx
    import byte_striping_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] lane0,
    output logic [WIDTH-1:0] lane1,
    output logic             valid_0,
    output logic             valid_1
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LIM = flush_limit(FLUSH_CYC);

    state_e                 state_q;
    state_e                 state_d;
    logic [WIDTH-1:0]       hold_q;
    logic [WIDTH-1:0]       hold_d;
    logic [FLUSH_CNT_W-1:0] flush_q;
    logic [FLUSH_CNT_W-1:0] flush_d;
    logic [WIDTH-1:0]       lane0_q;
    logic [WIDTH-1:0]       lane0_d;
    logic [WIDTH-1:0]       lane1_q;
    logic [WIDTH-1:0]       lane1_d;
    logic                   load_pair_s;
    logic                   load_flush_s;

    // Pairing decisions: capture the even word, complete a pair, or flush.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        flush_d      = flush_q;
        lane0_d      = lane0_q;
        lane1_d      = lane1_q;
        load_pair_s  = 1'b0;
        load_flush_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    hold_d  = data_in;
                    flush_d = '0;
                    state_d = HALF;
                end else begin
                    flush_d = '0;
                    state_d = IDLE;
                end
            end
            HALF: begin
                if (valid_in) begin
                    // Pair completion takes priority over a due flush.
                    lane0_d     = hold_q;
                    lane1_d     = data_in;
                    load_pair_s = 1'b1;
                    flush_d     = '0;
                    state_d     = IDLE;
                end else if (flush_q == FLUSH_LIM) begin
                    // Lone word goes out on lane0; lane1 keeps its value,
                    // and the next word realigns to the even lane.
                    lane0_d      = hold_q;
                    load_flush_s = 1'b1;
                    flush_d      = '0;
                    state_d      = IDLE;
                end else begin
                    flush_d = sat_inc4(flush_q);
                    state_d = HALF;
                end
            end
            default: begin
                flush_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, holding register, flush counter and lane data registers.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            flush_q <= '0;
            lane0_q <= '0;
            lane1_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            flush_q <= flush_d;
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
        end
    end

    lane_hold_timer u_timer (
        .clk_i         (clk_2f),
        .reset_i       (reset),
        .load_pair_i   (load_pair_s),
        .load_single_i (load_flush_s),
        .valid_0_o     (valid_0),
        .valid_1_o     (valid_1)
    );

    assign lane0 = lane0_q;
    assign lane1 = lane1_q;

endmodule

// File: doc/byte_striping_tx.md
BYTE_STRIPING_TX -- requirements
Module: byte_striping_tx

Interface
REQ-001 Parameter WIDTH, default 32: word and lane width in bits.
REQ-002 Parameter FLUSH_CYC, default 4: idle cycles before a lone pending word is flushed; legal range 1..15.
REQ-003 Port clk_2f, input, 1: the only clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port data_in, input, WIDTH: input word.
REQ-006 Port valid_in, input, 1: data_in is valid this cycle; the block always accepts, with no back-pressure.
REQ-007 Port lane0, output, WIDTH: even-numbered word of the current pair.
REQ-008 Port lane1, output, WIDTH: odd-numbered word of the current pair.
REQ-009 Port valid_0, output, 1: lane0 carries a valid word.
REQ-010 Port valid_1, output, 1: lane1 carries a valid word.

Function
REQ-011 The block SHALL have two states. IDLE means no word is pending. HALF means one word is held in hold_reg.
REQ-012 In IDLE with valid_in=1, the block SHALL capture data_in into hold_reg and go to HALF; outputs are unchanged by the capture.
REQ-013 In HALF with valid_in=1, the block SHALL, on the next edge, load lane0<=hold_reg, lane1<=data_in, valid_0<=1, valid_1<=1, and go to IDLE.
REQ-014 Each loaded pair SHALL be presented for exactly 2 cycles (one clk_f period). Then valid_0 and valid_1 drop to 0 unless a new load occurs on that edge.
REQ-015 When valid is deasserted, lane0 and lane1 SHALL hold their last values.
REQ-016 Latency: the pair SHALL appear on the outputs 1 cycle after the odd word is accepted.
REQ-017 At the sustained maximum rate (valid_in=1 every cycle), the lanes SHALL update every 2 cycles with no gaps and no overlap.
REQ-018 In HALF, a flush counter SHALL count consecutive cycles with valid_in=0. It clears on entry to HALF and on any valid_in=1.
REQ-019 When the flush counter reaches FLUSH_CYC, the block SHALL load lane0<=hold_reg, valid_0<=1, valid_1<=0, and go to IDLE; lane1 holds its old value.
REQ-020 A flushed word SHALL be presented for 2 cycles under the same rule as REQ-014.
REQ-021 If valid_in=1 on the same cycle the counter would reach FLUSH_CYC, pair completion (REQ-013) SHALL win and no flush occurs.
REQ-022 The word after a flush SHALL go to lane0, so the pair pointer is realigned to even.
REQ-023 The flush counter SHALL saturate and never wrap; it is 4 bits wide.
REQ-024 A load that coincides with the second presentation cycle of the previous pair SHALL restart the 2-cycle window without a valid gap.

Reset
REQ-025 While reset=1 at an edge, the block SHALL set: state=IDLE, hold_reg=0, flush counter=0, presentation counter=0, lane0=0, lane1=0, valid_0=0, valid_1=0.
REQ-026 Reset SHALL override valid_in on the same edge; a pending word is discarded.
REQ-027 Reset asserted mid-presentation SHALL drop both valids on the next edge.

Structure
REQ-028 Shared package byte_striping_pkg SHALL hold the state enum {IDLE, HALF}, the WIDTH default, and the FLUSH_CYC default; the matching Byte_Unstriping side imports the same package.
REQ-029 A single sub-module lane_hold_timer (2-cycle presentation counter and valid generation) is natural. Everything else stays in the top module.

Verification
REQ-030 Reset, then valid_in=1 for 4 cycles with 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> lane0/lane1 show 0x11111111/0x22222222 for 2 cycles, then 0x33333333/0x44444444 for 2 cycles, valid_0=valid_1=1 throughout, then 0.
REQ-031 Single word 0xA5A5A5A5, then valid_in=0 with FLUSH_CYC=4 -> after 4 idle cycles lane0=0xA5A5A5A5, valid_0=1, valid_1=0 for 2 cycles.
REQ-032 Word 0x1, 3 idle cycles, then word 0x2 on the 4th cycle -> pair 0x1/0x2 with both valids set, no flush.
REQ-033 Word 0xDEADBEEF, then reset=1 for 1 cycle, then words 0x5 and 0x6 -> pair 0x5/0x6; 0xDEADBEEF never appears.
REQ-034 Flush of 0x7, then words 0x8 and 0x9 -> lane0=0x8, lane1=0x9, confirming the pointer realigned to even.
REQ-035 Loopback into Byte_Unstriping with 8 back-to-back words -> data_out reproduces the input sequence in order.
